// File: rtl/addsub8_limb_stream_if.sv
// rtl/addsub8_limb_stream_if.sv - limb operand stream in, result limb stream out
interface addsub8_limb_stream_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 2
);
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             sub;
  logic             cin;
  logic             i_last;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o;
  logic [IDX_W-1:0] o_idx;
  logic             o_last;
  logic             cout;
  logic             o_err;

  modport slave (
    input  i_valid, i0, i1, sub, cin, i_last, o_ready,
    output i_ready, o_valid, o, o_idx, o_last, cout, o_err
  );

  modport master (
    output i_valid, i0, i1, sub, cin, i_last, o_ready,
    input  i_ready, o_valid, o, o_idx, o_last, cout, o_err
  );
endinterface

// File: rtl/addsub8_limb_stream.sv
// rtl/addsub8_limb_stream.sv - streaming multi-limb add/sub with registered carry
module addsub8_limb_stream #(
  parameter int WIDTH     = 8,
  parameter int MAX_LIMBS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  addsub8_limb_stream_if.slave  bus
);
  typedef enum logic {S_FIRST, S_CONT} state_t;

  state_t           state;
  logic             carry_q;
  logic             op_q;
  logic [IDX_W-1:0] idx_q;

  logic             accept;
  logic             is_first;
  logic             op_eff;
  logic             c_in;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             at_max;
  logic             forced;
  logic             ends_op;

  // Single output register: free when empty or being drained this cycle.
  assign bus.i_ready = !bus.o_valid || bus.o_ready;
  assign accept      = bus.i_valid && bus.i_ready;

  always_comb begin
    is_first = (state == S_FIRST);
    op_eff   = is_first ? bus.sub : op_q;
    // Subtract is I0 + ~I1 + ~borrow, so the first-limb borrow-in is inverted.
    c_in     = is_first ? (bus.sub ? ~bus.cin : bus.cin) : carry_q;
    b_op     = op_eff ? ~bus.i1 : bus.i1;
    sum      = {1'b0, bus.i0} + {1'b0, b_op} + {{WIDTH{1'b0}}, c_in};
    at_max   = (idx_q == IDX_W'(MAX_LIMBS - 1));
    forced   = at_max && !bus.i_last;
    ends_op  = bus.i_last || forced;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_FIRST;
      carry_q     <= 1'b0;
      op_q        <= 1'b0;
      idx_q       <= '0;
      bus.o_valid <= 1'b0;
      bus.o       <= '0;
      bus.o_idx   <= '0;
      bus.o_last  <= 1'b0;
      bus.cout    <= 1'b0;
      bus.o_err   <= 1'b0;
    end else begin
      if (bus.o_valid && bus.o_ready) begin
        bus.o_valid <= 1'b0;
      end
      if (accept) begin
        bus.o_valid <= 1'b1;
        bus.o       <= sum[WIDTH-1:0];
        bus.cout    <= sum[WIDTH];
        bus.o_idx   <= idx_q;
        bus.o_last  <= ends_op;
        bus.o_err   <= forced;
        carry_q     <= sum[WIDTH];
        if (is_first) begin
          op_q <= bus.sub;
        end
        // Truncation drops back to FIRST so the next limb uses fresh SUB/CIN.
        if (ends_op) begin
          state <= S_FIRST;
          idx_q <= '0;
        end else begin
          state <= S_CONT;
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_addsub8_limb_stream.sv
// tb/tb_addsub8_limb_stream.sv - randomized and directed bench with wide-integer reference model
module tb_addsub8_limb_stream;
  localparam int W    = 8;
  localparam int MAXL = 4;
  localparam int IW   = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  addsub8_limb_stream_if #(.WIDTH(W), .IDX_W(IW)) bus();

  addsub8_limb_stream #(.WIDTH(W), .MAX_LIMBS(MAXL), .IDX_W(IW)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] o;
    int         idx;
    bit         last;
    bit         err;
    bit         cout;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t       exp_q[$];
  logic [7:0] log_o[$];
  int         log_idx[$];
  bit         log_last[$];
  bit         log_err[$];
  bit         log_cout[$];

  // Model: operands accumulate as wide integers; limb k of the result is
  // bits [8k+7:8k] of the prefix sum/difference over limbs 0..k.
  bit     in_op = 0;
  bit     m_sub, m_cin;
  longint a_acc, b_acc;
  int     n_limbs;
  bit     rand_rdy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_accept(input logic [7:0] i0, input logic [7:0] i1,
                              input bit sub, input bit cin, input bit last);
    longint t;
    exp_t   e;
    if (!in_op) begin
      m_sub = sub; m_cin = cin; a_acc = 0; b_acc = 0; n_limbs = 0;
    end
    a_acc = a_acc | (longint'(i0) << (8 * n_limbs));
    b_acc = b_acc | (longint'(i1) << (8 * n_limbs));
    n_limbs++;
    t = m_sub ? (a_acc - b_acc - longint'(m_cin)) : (a_acc + b_acc + longint'(m_cin));
    if (t < 0) t = t + (longint'(1) << (8 * n_limbs + 1));
    e.o    = 8'((t >> (8 * (n_limbs - 1))) & 64'hFF);
    e.idx  = n_limbs - 1;
    e.cout = m_sub ? (a_acc >= b_acc + longint'(m_cin)) : bit'((t >> (8 * n_limbs)) & 1);
    e.last = last || (n_limbs == MAXL);
    e.err  = !last && (n_limbs == MAXL);
    in_op  = !e.last;
    exp_q.push_back(e);
  endtask

  // Compare process: inputs/o_ready change just after posedge, so the negedge
  // sees exactly what the next posedge will act on.
  initial begin : monitor
    bit         hold_prev;
    logic [7:0] s_o;
    logic [1:0] s_idx;
    logic       s_last, s_err, s_cout;
    exp_t       e;
    hold_prev = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        in_op = 0;
        exp_q.delete();
        hold_prev = 0;
      end else begin
        chk("i_ready", 64'(bus.i_ready), 64'(!bus.o_valid || bus.o_ready));
        if (hold_prev) begin
          chk("hold_valid", 64'(bus.o_valid), 64'd1);
          chk("hold_o", 64'(bus.o), 64'(s_o));
          chk("hold_idx", 64'(bus.o_idx), 64'(s_idx));
          chk("hold_flags", {61'd0, bus.o_last, bus.o_err, bus.cout}, {61'd0, s_last, s_err, s_cout});
        end
        if (bus.o_valid && bus.o_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'(bus.o_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("o", 64'(bus.o), 64'(e.o));
            chk("o_idx", 64'(bus.o_idx), 64'(e.idx));
            chk("o_last", 64'(bus.o_last), 64'(e.last));
            chk("o_err", 64'(bus.o_err), 64'(e.err));
            if (e.last) chk("cout", 64'(bus.cout), 64'(e.cout));
          end
          log_o.push_back(bus.o);
          log_idx.push_back(int'(bus.o_idx));
          log_last.push_back(bus.o_last);
          log_err.push_back(bus.o_err);
          log_cout.push_back(bus.cout);
        end
        if (bus.i_valid && bus.i_ready)
          model_accept(bus.i0, bus.i1, bus.sub, bus.cin, bus.i_last);
        hold_prev = bus.o_valid && !bus.o_ready;
        s_o = bus.o; s_idx = bus.o_idx; s_last = bus.o_last; s_err = bus.o_err; s_cout = bus.cout;
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.o_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit s, input bit c, input bit l);
    int tries;
    bus.i_valid = 1'b1; bus.i0 = a; bus.i1 = b; bus.sub = s; bus.cin = c; bus.i_last = l;
    tries = 0;
    forever begin
      @(negedge clk);
      if (bus.i_ready) break;
      tries++;
      if (tries > 200) begin
        chk("send_timeout", 64'(bus.i_ready), 64'd1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.o_valid) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 500) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_log(input string name, input int i, input logic [7:0] o, input int idx,
                         input bit last, input bit err);
    if (i >= log_o.size()) begin
      chk({name, "_missing"}, 64'(log_o.size()), 64'(i + 1));
    end else begin
      chk({name, "_o"}, 64'(log_o[i]), 64'(o));
      chk({name, "_idx"}, 64'(log_idx[i]), 64'(idx));
      chk({name, "_last_err"}, {62'd0, log_last[i], log_err[i]}, {62'd0, last, err});
    end
  endtask

  initial begin : stim
    int  base;
    bit  fork_done;
    resetn = 1'b0;
    bus.i_valid = 0; bus.i0 = 0; bus.i1 = 0; bus.sub = 0; bus.cin = 0; bus.i_last = 0;
    bus.o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(bus.o_valid), 64'd0);
    chk("reset_outs", {bus.o, bus.o_idx, bus.o_last, bus.cout, bus.o_err}, 64'd0);
    resetn = 1'b1;

    // 0x01FF + 0x0001
    base = log_o.size();
    send(8'hFF, 8'h01, 0, 0, 0);
    send(8'h01, 8'h00, 0, 0, 1);
    drain();
    chk_log("add_l0", base, 8'h00, 0, 0, 0);
    chk_log("add_l1", base + 1, 8'h02, 1, 1, 0);
    if (base + 1 < log_cout.size()) chk("add_cout", 64'(log_cout[base + 1]), 64'd0);

    // 0x0100 - 0x0001 = 0x00FF, no borrow
    base = log_o.size();
    send(8'h00, 8'h01, 1, 0, 0);
    send(8'h01, 8'h00, 1, 0, 1);
    drain();
    chk_log("sub_l0", base, 8'hFF, 0, 0, 0);
    chk_log("sub_l1", base + 1, 8'h00, 1, 1, 0);
    if (base + 1 < log_cout.size()) chk("sub_cout", 64'(log_cout[base + 1]), 64'd1);

    // 0x0000 - 0x0001 borrows, then single-limb 0x80 + 0x80 + 1
    base = log_o.size();
    send(8'h00, 8'h01, 1, 0, 0);
    send(8'h00, 8'h00, 1, 0, 1);
    send(8'h80, 8'h80, 0, 1, 1);
    drain();
    chk_log("borrow_l0", base, 8'hFF, 0, 0, 0);
    chk_log("borrow_l1", base + 1, 8'hFF, 1, 1, 0);
    chk_log("single", base + 2, 8'h01, 0, 1, 0);
    if (base + 2 < log_cout.size()) begin
      chk("borrow_cout", 64'(log_cout[base + 1]), 64'd0);
      chk("single_cout", 64'(log_cout[base + 2]), 64'd1);
    end

    // Backpressure: stall output for three cycles mid-stream
    base = log_o.size();
    fork_done = 0;
    fork
      begin
        send(8'h11, 8'h22, 0, 0, 0);
        send(8'h33, 8'h44, 0, 0, 0);
        send(8'h55, 8'h66, 0, 0, 0);
        send(8'h77, 8'h88, 0, 0, 1);
        fork_done = 1;
      end
    join_none
    @(posedge clk); #1;
    bus.o_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_i_ready", 64'(bus.i_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.o_ready = 1'b1;
    for (int k = 0; k < 50 && !fork_done; k++) begin
      @(posedge clk); #1;
    end
    chk("stall_stream_done", 64'(fork_done), 64'd1);
    drain();
    chk_log("stall_l0", base, 8'h33, 0, 0, 0);
    chk_log("stall_l1", base + 1, 8'h77, 1, 0, 0);
    chk_log("stall_l2", base + 2, 8'hBB, 2, 0, 0);
    chk_log("stall_l3", base + 3, 8'hFF, 3, 1, 0);

    // Five limbs without LAST: truncation at MAX_LIMBS, fifth starts fresh with CIN=1
    base = log_o.size();
    for (int k = 0; k < 4; k++) send(8'h01, 8'h01, 0, 0, 0);
    send(8'h10, 8'h20, 0, 1, 0);
    send(8'h00, 8'h00, 0, 0, 1);
    drain();
    chk_log("force_l3", base + 3, 8'h02, 3, 1, 1);
    chk_log("force_next", base + 4, 8'h31, 0, 0, 0);
    chk_log("force_tail", base + 5, 8'h00, 1, 1, 0);

    // Reset mid-operation discards the partial result
    base = log_o.size();
    send(8'hFF, 8'hFF, 0, 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midreset_valid", 64'(bus.o_valid), 64'd0);
    chk("midreset_outs", {bus.o, bus.o_idx, bus.o_last, bus.cout, bus.o_err}, 64'd0);
    resetn = 1'b1;
    send(8'hFF, 8'h00, 0, 0, 1);
    drain();
    chk_log("after_reset", base + 1, 8'hFF, 0, 1, 0);
    if (base + 1 < log_cout.size()) chk("after_reset_cout", 64'(log_cout[base + 1]), 64'd0);

    // Random operations with random backpressure and idle gaps
    rand_rdy = 1;
    for (int op = 0; op < 250; op++) begin
      int len;
      bit s, c;
      len = $urandom_range(1, 6);
      s = 1'($urandom); c = 1'($urandom);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        send(8'($urandom), 8'($urandom), (k == 0) ? s : 1'($urandom),
             (k == 0) ? c : 1'($urandom), k == len - 1);
      end
    end
    rand_rdy = 0;
    bus.o_ready = 1'b1;
    drain();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/addsub8_limb_stream.md
Name: addsub8_limb_stream

Overview:
- Streaming multi-limb adder/subtractor. Wide operands arrive as 8-bit limbs, least-significant limb first, one limb pair per handshake.
- The carry is held in a register between limbs. The block emits one result limb per input limb and a final carry-out.
- Sits between operand buffers and a result FIFO. Lets a single 8-bit carry chain perform N×8-bit add/sub over successive cycles.

Parameters:
- WIDTH, 8, limb width in bits.
- MAX_LIMBS, 4, maximum limbs per operation before forced termination (≥1).
- IDX_W, 2, width of the limb index; must satisfy 2^IDX_W ≥ MAX_LIMBS.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESETN  input  1  synchronous active-low reset, sampled on rising CLK.
- I_VALID  input  1  input limb pair valid.
- I_READY  output  1  block accepts input this cycle.
- I0  input  WIDTH  minuend/augend limb.
- I1  input  WIDTH  subtrahend/addend limb.
- SUB  input  1  0=add, 1=subtract; sampled on first limb only.
- CIN  input  1  carry-in (add) or borrow-in (sub); sampled on first limb only.
- I_LAST  input  1  marks most-significant limb.
- O_VALID  output  1  result limb valid.
- O_READY  input  1  downstream accepts result.
- O  output  WIDTH  result limb.
- O_IDX  output  IDX_W  limb index of O (0 = least significant).
- O_LAST  output  1  final limb of the operation.
- COUT  output  1  raw carry out of the current limb; meaningful when O_LAST=1.
- O_ERR  output  1  operation truncated at MAX_LIMBS; asserted only with O_LAST.

Behaviour:
- State machine, two states:
  - FIRST: next accepted limb starts a new operation.
  - CONT: mid-operation.
  - An accept with I_LAST=1, or a forced termination, moves to FIRST. Any other accept moves to CONT.
- Reset (RESETN=0 at edge): state=FIRST; carry reg=0; op reg=0; idx=0; O_VALID=0; O=0; O_IDX=0; O_LAST=0; COUT=0; O_ERR=0. Applies mid-operation: the partial result is discarded, and the next accepted limb is a first limb.
- Handshake:
  - Accept when I_VALID && I_READY.
  - Emit completes when O_VALID && O_READY.
  - I_READY = !O_VALID || O_READY (combinational). This gives a single output register with full throughput: one limb per cycle when O_READY is held high.
- Latency: accepted limb appears on O one cycle later (registered outputs).
- Arithmetic per accepted limb, with c the carry-in:
  - First limb: c = SUB ? ~CIN : CIN, and SUB is latched into the op reg.
  - Later limbs: c = carry reg.
  - Operand: B = op ? ~I1 : I1.
  - Sum: {c_out, r} = I0 + B + c, computed at WIDTH+1 bits.
  - O ← r; COUT ← c_out; carry reg ← c_out.
- Subtract convention: result = I0 − I1 − CIN. COUT=1 means no borrow; COUT=0 means borrow.
- Index: O_IDX ← 0 on first limb, else previous idx+1. The idx reg resets to 0 when returning to FIRST.
- Normal termination: an accepted limb with I_LAST=1 gives O_LAST=1, O_ERR=0.
- Forced termination: an accepted limb with idx = MAX_LIMBS−1 and I_LAST=0 gives O_LAST=1, O_ERR=1, and state → FIRST. The next limb starts a new operation using fresh SUB/CIN.
- Single-limb op (I_LAST=1 on first limb) is legal: O_IDX=0, O_LAST=1.
- Backpressure: while O_VALID && !O_READY, all output regs and internal state hold, and I_READY=0.
- SUB/CIN changes on non-first limbs are ignored.
- Output signals are stable while O_VALID=1 and not yet taken.

Test Plan:
- Add 0x01FF+0x0001, CIN=0, limbs (FF,01),(01,00)+LAST -> O=00 idx0; then O=02 idx1, O_LAST=1, COUT=0.
- Sub 0x0100−0x0001, CIN=0 -> O=FF, then O=00, O_LAST=1, COUT=1 (no borrow); result 0x00FF.
- Sub 0x0000−0x0001, CIN=0 -> O=FF, then FF, COUT=0 (borrow); then an immediate add 0x80+0x80, CIN=1, single limb -> O=01, COUT=1, O_IDX=0.
- Hold O_READY=0 for 3 cycles mid-stream -> I_READY=0, O/O_IDX/COUT stable; on release, continuous one-per-cycle flow with no lost or duplicated limbs.
- MAX_LIMBS=4: five limbs with no LAST -> 4th limb O_LAST=1, O_ERR=1; 5th limb treated as first (O_IDX=0, carry from its own CIN).
- RESETN=0 for one cycle after limb 1 of 3 -> all outputs 0, O_VALID=0; next limb computed with fresh CIN, O_IDX=0.
